// File: rtl/mcr_rom_arb_pkg.sv
// Shared types for the ROM port arbiter: reset sequencer states and BRAM grant owners.
package mcr_rom_arb_pkg;

   typedef enum logic [1:0] {
      SeqUnloaded,
      SeqLoading,
      SeqStretch,
      SeqRun
   } seq_state_t;

   typedef enum logic [1:0] {
      GntNone,
      GntDl,
      GntMain,
      GntSnd
   } grant_t;

endpackage

// File: rtl/rom_rst_seq.sv
// Core reset sequencer: holds the core in reset until a ROM is loaded, then stretches every
// load or user reset for RST_CYCLES clocks before releasing it.
module rom_rst_seq
   import mcr_rom_arb_pkg::*;
#(
   parameter int unsigned RST_CYCLES = 65535
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic dl_active,
   input  logic user_reset,
   output logic core_reset,
   output logic rom_loaded
);

   localparam logic [15:0] RstLoad = 16'(RST_CYCLES);

   seq_state_t  state_q;
   logic [15:0] count_q;
   logic        dl_active_q;
   logic        dl_rise;

   assign dl_rise = dl_active & ~dl_active_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SeqUnloaded;
         count_q     <= '0;
         dl_active_q <= 1'b0;
         core_reset  <= 1'b1;
         rom_loaded  <= 1'b0;
      end else begin
         dl_active_q <= dl_active;
         // A new download restarts the sequence from any state.
         if (dl_rise) begin
            state_q    <= SeqLoading;
            core_reset <= 1'b1;
         end else begin
            unique case (state_q)
               SeqUnloaded: begin
               end
               SeqLoading: begin
                  if (!dl_active) begin
                     state_q    <= SeqStretch;
                     count_q    <= RstLoad;
                     rom_loaded <= 1'b1;
                  end
               end
               SeqStretch: begin
                  if (user_reset) begin
                     count_q <= RstLoad;
                  end else if (count_q <= 16'd1) begin
                     // Final decrement lands on zero together with the release.
                     state_q    <= SeqRun;
                     count_q    <= '0;
                     core_reset <= 1'b0;
                  end else begin
                     count_q <= count_q - 16'd1;
                  end
               end
               SeqRun: begin
                  if (user_reset) begin
                     state_q    <= SeqStretch;
                     count_q    <= RstLoad;
                     core_reset <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one single-port BRAM between the ROM download writer and the main/sound CPU fetch ports.
// Define ROM_ARB_CHECKSUM_EN to add the dl_sum download checksum output.
module rom_port_arbiter
   import mcr_rom_arb_pkg::*;
#(
   parameter int unsigned AW         = 16,
   parameter int unsigned DW         = 8,
   parameter int unsigned RST_CYCLES = 65535
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          dl_active,
   input  logic          dl_wr,
   input  logic [AW-1:0] dl_addr,
   input  logic [DW-1:0] dl_data,
   input  logic          m_req,
   input  logic [AW-1:0] m_addr,
   output logic          m_ack,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   input  logic          s_req,
   input  logic [AW-1:0] s_addr,
   output logic          s_ack,
   output logic          s_valid,
   output logic [DW-1:0] s_data,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_d,
   input  logic [DW-1:0] ram_q,
   input  logic          user_reset,
   output logic          core_reset,
   output logic          rom_loaded
`ifdef ROM_ARB_CHECKSUM_EN
   ,
   output logic [15:0]   dl_sum
`endif
);

   grant_t          grant;
   grant_t          last_q;
   logic            dl_write;
   logic            m_valid_q;
   logic            s_valid_q;
   logic [DW-1:0]   m_hold_q;
   logic [DW-1:0]   s_hold_q;

   assign dl_write = dl_active & dl_wr;

   // Fetches are locked out for the whole download, not just on write cycles.
   always_comb begin
      grant = GntNone;
      if (reset_n) begin
         if (dl_write) begin
            grant = GntDl;
         end else if (!dl_active) begin
            if (m_req && s_req) begin
               grant = (last_q == GntMain) ? GntSnd : GntMain;
            end else if (m_req) begin
               grant = GntMain;
            end else if (s_req) begin
               grant = GntSnd;
            end
         end
      end
   end

   always_comb begin
      ram_addr = '0;
      ram_we   = 1'b0;
      ram_d    = dl_data;
      unique case (grant)
         GntDl: begin
            ram_addr = dl_addr;
            ram_we   = 1'b1;
         end
         GntMain: ram_addr = m_addr;
         GntSnd:  ram_addr = s_addr;
         GntNone: begin
         end
      endcase
   end

   assign m_ack = (grant == GntMain);
   assign s_ack = (grant == GntSnd);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         last_q    <= GntSnd;
         m_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
         m_hold_q  <= '0;
         s_hold_q  <= '0;
      end else begin
         m_valid_q <= (grant == GntMain);
         s_valid_q <= (grant == GntSnd);
         if (grant == GntMain || grant == GntSnd) begin
            last_q <= grant;
         end
         if (m_valid_q) begin
            m_hold_q <= ram_q;
         end
         if (s_valid_q) begin
            s_hold_q <= ram_q;
         end
      end
   end

   // BRAM output is live in the valid cycle; the hold copy keeps it afterwards.
   assign m_valid = m_valid_q;
   assign s_valid = s_valid_q;
   assign m_data  = m_valid_q ? ram_q : m_hold_q;
   assign s_data  = s_valid_q ? ram_q : s_hold_q;

`ifdef ROM_ARB_CHECKSUM_EN
   logic        sum_dl_q;
   logic [15:0] sum_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sum_dl_q <= 1'b0;
         sum_q    <= '0;
      end else begin
         sum_dl_q <= dl_active;
         if (dl_active && !sum_dl_q) begin
            sum_q <= dl_write ? 16'(dl_data) : 16'h0000;
         end else if (dl_write) begin
            sum_q <= sum_q + 16'(dl_data);
         end
      end
   end

   assign dl_sum = sum_q;
`endif

   rom_rst_seq #(
      .RST_CYCLES (RST_CYCLES)
   ) u_rst_seq (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .dl_active  (dl_active),
      .user_reset (user_reset),
      .core_reset (core_reset),
      .rom_loaded (rom_loaded)
   );

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: BRAM model plus a behavioural grant/data reference.
module tb_rom_port_arbiter;

   localparam int unsigned AW         = 16;
   localparam int unsigned DW         = 8;
   localparam int unsigned RST_CYCLES = 16;

   logic          clk_sys    = 1'b0;
   logic          reset_n    = 1'b0;
   logic          dl_active  = 1'b0;
   logic          dl_wr      = 1'b0;
   logic [AW-1:0] dl_addr    = '0;
   logic [DW-1:0] dl_data    = '0;
   logic          m_req      = 1'b0;
   logic [AW-1:0] m_addr     = '0;
   logic          m_ack;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          s_req      = 1'b0;
   logic [AW-1:0] s_addr     = '0;
   logic          s_ack;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_d;
   logic [DW-1:0] ram_q      = '0;
   logic          user_reset = 1'b0;
   logic          core_reset;
   logic          rom_loaded;
`ifdef ROM_ARB_CHECKSUM_EN
   logic [15:0]   dl_sum;
`endif

   // Reference state
   logic [DW-1:0] bram    [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   int            errors   = 0;
   int            checks   = 0;
   int            we_count = 0;
   bit            last_snd = 1'b1;
   bit            exp_mv   = 1'b0;
   bit            exp_sv   = 1'b0;
   logic [DW-1:0] exp_md   = '0;
   logic [DW-1:0] exp_sd   = '0;
   bit            m_pend   = 1'b0;
   bit            s_pend   = 1'b0;
   logic [15:0]   exp_sum  = '0;

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) begin
      if (ram_we === 1'b1) begin
         bram[ram_addr] <= ram_d;
         we_count       <= we_count + 1;
      end
      ram_q <= bram[ram_addr];
   end

   rom_port_arbiter #(
      .AW         (AW),
      .DW         (DW),
      .RST_CYCLES (RST_CYCLES)
   ) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .dl_active  (dl_active),
      .dl_wr      (dl_wr),
      .dl_addr    (dl_addr),
      .dl_data    (dl_data),
      .m_req      (m_req),
      .m_addr     (m_addr),
      .m_ack      (m_ack),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .s_req      (s_req),
      .s_addr     (s_addr),
      .s_ack      (s_ack),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_d      (ram_d),
      .ram_q      (ram_q),
      .user_reset (user_reset),
      .core_reset (core_reset),
      .rom_loaded (rom_loaded)
`ifdef ROM_ARB_CHECKSUM_EN
      ,
      .dl_sum     (dl_sum)
`endif
   );

   function automatic logic [AW-1:0] rand_rom_addr();
      return 16'h0100 + 16'($urandom_range(0, 63));
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; dl_active = 1'b1; dl_wr = 1'b1; dl_addr = 16'h0005; dl_data = 8'h5A;
      m_req = 1'b1; s_req = 1'b1; m_addr = 16'h0001; s_addr = 16'h0002;
      repeat (3) @(negedge clk_sys);
      #1;
      checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset: got %b want 1", core_reset); end
      checks++; if (rom_loaded !== 1'b0) begin errors++; $display("FAIL reset_rom_loaded: got %b want 0", rom_loaded); end
      checks++; if (m_ack !== 1'b0 || s_ack !== 1'b0) begin errors++; $display("FAIL reset_acks: got m=%b s=%b want 0 0", m_ack, s_ack); end
      checks++; if (m_valid !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL reset_valids: got m=%b s=%b want 0 0", m_valid, s_valid); end
      checks++; if (m_data !== 8'h00 || s_data !== 8'h00) begin errors++; $display("FAIL reset_data: got m=%h s=%h want 00 00", m_data, s_data); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
      @(negedge clk_sys);
      dl_active = 1'b0; dl_wr = 1'b0; m_req = 1'b0; s_req = 1'b0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      last_snd = 1'b1; exp_mv = 1'b0; exp_sv = 1'b0; exp_md = '0; exp_sd = '0;
      // No download: user_reset and stray dl_wr must do nothing.
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_sys);
         user_reset = 1'($urandom_range(0, 1));
         dl_wr      = 1'($urandom_range(0, 1));
         dl_addr    = 16'($urandom());
         #1;
         checks++; if (core_reset !== 1'b1 || rom_loaded !== 1'b0) begin errors++; $display("FAIL unloaded_hold: cyc %0d got core_reset=%b rom_loaded=%b want 1 0", i, core_reset, rom_loaded); end
         checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL dl_wr_ignored: cyc %0d got ram_we=%b want 0", i, ram_we); end
      end
      user_reset = 1'b0; dl_wr = 1'b0;
   endtask

   task automatic test_download();
      int base;
      base = we_count;
      exp_sum = '0;
      @(negedge clk_sys);
      dl_active = 1'b1; dl_wr = 1'b0;
      #1;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL dl_idle_we: got %b want 0", ram_we); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_sys);
         dl_wr = 1'b1; dl_addr = 16'(i); dl_data = 8'(8'h11 * (i + 1));
         #1;
         checks++;
         if (ram_we !== 1'b1 || ram_addr !== 16'(i) || ram_d !== 8'(8'h11 * (i + 1))) begin
            errors++;
            $display("FAIL dl_write_%0d: got we=%b addr=%h d=%h want 1 %h %h", i, ram_we, ram_addr, ram_d, 16'(i), 8'(8'h11 * (i + 1)));
         end
         ref_mem[16'(i)] = dl_data;
         exp_sum = exp_sum + 16'(dl_data);
      end
      @(negedge clk_sys);
      dl_wr = 1'b0; dl_active = 1'b0;
      #1;
      checks++; if (we_count - base != 4) begin errors++; $display("FAIL dl_we_pulses: got %0d want 4", we_count - base); end
      for (int j = 0; j <= 20; j++) begin
         @(negedge clk_sys);
         #1;
         checks++; if (rom_loaded !== 1'b1) begin errors++; $display("FAIL rom_loaded_set: j=%0d got %b want 1", j, rom_loaded); end
         checks++; if (core_reset !== (j < int'(RST_CYCLES))) begin errors++; $display("FAIL load_stretch: j=%0d got core_reset=%b want %b", j, core_reset, (j < int'(RST_CYCLES))); end
      end
`ifdef ROM_ARB_CHECKSUM_EN
      checks++; if (dl_sum !== 16'h00AA) begin errors++; $display("FAIL dl_sum_fixed: got %h want 00aa", dl_sum); end
`endif
   endtask

   task automatic test_load_random();
      int written;
      written = 0;
      exp_sum = '0;
      for (int c = 0; c < 400 && written < 64; c++) begin
         @(negedge clk_sys);
         dl_active = 1'b1;
         dl_wr     = (written == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         dl_addr   = 16'h0100 + 16'(written);
         dl_data   = 8'($urandom());
         #1;
         checks++; if (ram_we !== dl_wr) begin errors++; $display("FAIL rand_dl_we: cyc %0d got %b want %b", c, ram_we, dl_wr); end
         if (dl_wr) begin
            ref_mem[dl_addr] = dl_data;
            exp_sum = exp_sum + 16'(dl_data);
            written++;
         end
      end
      @(negedge clk_sys);
      dl_active = 1'b0; dl_wr = 1'b0;
      $display("info: random download of %0d bytes, checksum %h", written, exp_sum);
      repeat (RST_CYCLES + 4) @(negedge clk_sys);
      #1;
      checks++; if (core_reset !== 1'b0 || rom_loaded !== 1'b1) begin errors++; $display("FAIL rand_load_run: got core_reset=%b rom_loaded=%b want 0 1", core_reset, rom_loaded); end
`ifdef ROM_ARB_CHECKSUM_EN
      checks++; if (dl_sum !== exp_sum) begin errors++; $display("FAIL dl_sum_rand: got %h want %h", dl_sum, exp_sum); end
`endif
   endtask

   task automatic test_round_robin();
      bit m_took;
      bit s_took;
      m_took = 1'b0; s_took = 1'b0;
      @(negedge clk_sys);
      reset_n = 1'b0; m_req = 1'b1; s_req = 1'b1;
      m_addr = rand_rom_addr(); s_addr = rand_rom_addr();
      #1;
      checks++; if (m_ack !== 1'b0 || s_ack !== 1'b0) begin errors++; $display("FAIL rr_reset_acks: got m=%b s=%b want 0 0", m_ack, s_ack); end
      exp_mv = 1'b0; exp_sv = 1'b0; exp_md = '0; exp_sd = '0;
      // Both ports held busy from reset: main first, then strict alternation.
      for (int k = 0; k < 12; k++) begin
         @(negedge clk_sys);
         if (k == 0) reset_n = 1'b1;
         if (m_took) m_addr = rand_rom_addr();
         if (s_took) s_addr = rand_rom_addr();
         #1;
         checks++; if (m_ack !== (k % 2 == 0) || s_ack !== (k % 2 == 1)) begin errors++; $display("FAIL rr_ack_%0d: got m=%b s=%b want %b %b", k, m_ack, s_ack, (k % 2 == 0), (k % 2 == 1)); end
         checks++; if (m_valid !== exp_mv || m_data !== exp_md) begin errors++; $display("FAIL rr_m_data_%0d: got v=%b d=%h want %b %h", k, m_valid, m_data, exp_mv, exp_md); end
         checks++; if (s_valid !== exp_sv || s_data !== exp_sd) begin errors++; $display("FAIL rr_s_data_%0d: got v=%b d=%h want %b %h", k, s_valid, s_data, exp_sv, exp_sd); end
         m_took = (k % 2 == 0);
         s_took = !m_took;
         exp_mv = m_took;
         exp_sv = s_took;
         if (m_took) exp_md = ref_mem[m_addr];
         if (s_took) exp_sd = ref_mem[s_addr];
      end
      last_snd = 1'b1;
      m_pend   = 1'b0;
      s_pend   = 1'b0;
   endtask

   task automatic test_random_fetch();
      bit want_m;
      bit want_s;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk_sys);
         if (!m_pend) begin m_req = 1'($urandom_range(0, 1)); m_addr = rand_rom_addr(); end
         if (!s_pend) begin s_req = 1'($urandom_range(0, 1)); s_addr = rand_rom_addr(); end
         #1;
         want_m = m_req && (!s_req || last_snd);
         want_s = s_req && (!m_req || !last_snd);
         checks++; if (m_ack !== want_m || s_ack !== want_s) begin errors++; $display("FAIL rand_ack_%0d: got m=%b s=%b want %b %b", c, m_ack, s_ack, want_m, want_s); end
         checks++; if ((want_m && ram_addr !== m_addr) || (want_s && ram_addr !== s_addr)) begin errors++; $display("FAIL rand_ram_addr_%0d: got %h want %h", c, ram_addr, want_m ? m_addr : s_addr); end
         checks++; if (m_valid !== exp_mv || m_data !== exp_md) begin errors++; $display("FAIL rand_m_data_%0d: got v=%b d=%h want %b %h", c, m_valid, m_data, exp_mv, exp_md); end
         checks++; if (s_valid !== exp_sv || s_data !== exp_sd) begin errors++; $display("FAIL rand_s_data_%0d: got v=%b d=%h want %b %h", c, s_valid, s_data, exp_sv, exp_sd); end
         exp_mv = want_m;
         exp_sv = want_s;
         if (want_m) begin exp_md = ref_mem[m_addr]; last_snd = 1'b0; end
         if (want_s) begin exp_sd = ref_mem[s_addr]; last_snd = 1'b1; end
         m_pend = m_req && !want_m;
         s_pend = s_req && !want_s;
      end
   endtask

   task automatic test_dl_interrupt();
      bit want_m;
      bit want_s;
      exp_sum = '0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk_sys);
         m_req = 1'b1; s_req = 1'b1;
         if (!m_pend) m_addr = rand_rom_addr();
         if (!s_pend) s_addr = rand_rom_addr();
         dl_active = (c >= 1 && c <= 6);
         dl_wr     = dl_active && (c == 1 || 1'($urandom_range(0, 1)));
         dl_addr   = 16'h0200 + 16'(c);
         dl_data   = 8'($urandom());
         #1;
         want_m = !dl_active && (!s_req || last_snd);
         want_s = !dl_active && (!m_req || !last_snd);
         checks++; if (m_ack !== want_m || s_ack !== want_s) begin errors++; $display("FAIL dlint_ack_%0d: got m=%b s=%b want %b %b", c, m_ack, s_ack, want_m, want_s); end
         checks++; if (ram_we !== dl_wr) begin errors++; $display("FAIL dlint_we_%0d: got %b want %b", c, ram_we, dl_wr); end
         checks++; if (m_valid !== exp_mv || m_data !== exp_md) begin errors++; $display("FAIL dlint_m_data_%0d: got v=%b d=%h want %b %h", c, m_valid, m_data, exp_mv, exp_md); end
         checks++; if (s_valid !== exp_sv || s_data !== exp_sd) begin errors++; $display("FAIL dlint_s_data_%0d: got v=%b d=%h want %b %h", c, s_valid, s_data, exp_sv, exp_sd); end
         if (c == 1) begin
            checks++; if ((m_valid | s_valid) !== 1'b1) begin errors++; $display("FAIL dlint_inflight_valid: got m=%b s=%b want one set", m_valid, s_valid); end
         end
         if (dl_wr) begin
            ref_mem[dl_addr] = dl_data;
            exp_sum = exp_sum + 16'(dl_data);
         end
         exp_mv = want_m;
         exp_sv = want_s;
         if (want_m) begin exp_md = ref_mem[m_addr]; last_snd = 1'b0; end
         if (want_s) begin exp_sd = ref_mem[s_addr]; last_snd = 1'b1; end
         m_pend = !want_m;
         s_pend = !want_s;
      end
      @(negedge clk_sys);
      m_req = 1'b0; s_req = 1'b0; m_pend = 1'b0; s_pend = 1'b0;
      #1;
`ifdef ROM_ARB_CHECKSUM_EN
      checks++; if (dl_sum !== exp_sum) begin errors++; $display("FAIL dl_sum_interrupt: got %h want %h", dl_sum, exp_sum); end
`endif
   endtask

   task automatic test_user_reset();
      bit seen;
      int gap;
      seen = 1'b0;
      m_req = 1'b0; s_req = 1'b0; dl_active = 1'b0; dl_wr = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk_sys);
         #1;
         if (core_reset === 1'b0) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL ureset_wait_run: got core_reset=%b want 0 within 40 cycles", core_reset); end
      @(negedge clk_sys);
      user_reset = 1'b1;
      #1;
      checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL ureset_pre: got %b want 0", core_reset); end
      gap = $urandom_range(2, 12);
      for (int j = 0; j < gap; j++) begin
         @(negedge clk_sys);
         user_reset = 1'b0;
         #1;
         checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL ureset_first_%0d: got %b want 1", j, core_reset); end
      end
      // Second pulse mid-stretch restarts the full count.
      @(negedge clk_sys);
      user_reset = 1'b1;
      #1;
      checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL ureset_second: got %b want 1", core_reset); end
      for (int j = 0; j < 20; j++) begin
         @(negedge clk_sys);
         user_reset = 1'b0;
         #1;
         checks++; if (core_reset !== (j < int'(RST_CYCLES))) begin errors++; $display("FAIL ureset_restart_%0d: got %b want %b", j, core_reset, (j < int'(RST_CYCLES))); end
         checks++; if (rom_loaded !== 1'b1) begin errors++; $display("FAIL ureset_rom_loaded_%0d: got %b want 1", j, rom_loaded); end
      end
   endtask

   initial begin
      test_reset();
      test_download();
      test_load_random();
      test_round_robin();
      test_random_fetch();
      test_dl_interrupt();
      test_user_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16: ROM address width.
REQ-002 SHALL have parameter DW, default 8: ROM data width.
REQ-003 SHALL have parameter RST_CYCLES, default 65535: post-load/user reset stretch length in clocks, 16-bit.
REQ-004 SHALL have port clk_sys  in  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports dl_active in 1 ROM download in progress; dl_wr in 1 byte strobe; dl_addr in AW; dl_data in DW.
REQ-007 SHALL have ports m_req in 1, m_addr in AW, m_ack out 1, m_valid out 1, m_data out DW: main CPU fetch port.
REQ-008 SHALL have ports s_req in 1, s_addr in AW, s_ack out 1, s_valid out 1, s_data out DW: sound CPU fetch port.
REQ-009 SHALL have ports ram_addr out AW, ram_we out 1, ram_d out DW, ram_q in DW: single-port BRAM with 1-cycle read latency.
REQ-010 SHALL have ports user_reset in 1 (OSD/button reset), core_reset out 1, rom_loaded out 1.

Function
REQ-011 SHALL arbitrate the BRAM every cycle; priority is download write, then main/sound round-robin.
REQ-012 SHALL, when dl_active and dl_wr, drive ram_we=1, ram_addr=dl_addr, ram_d=dl_data in the same cycle; dl_wr with dl_active=0 is ignored.
REQ-013 SHALL never assert m_ack or s_ack while dl_active=1.
REQ-014 SHALL grant a fetch combinationally: ack in cycle N with ram_addr = granted address in cycle N; x_valid pulses 1 cycle in N+1 with x_data = ram_q registered.
REQ-015 SHALL hold x_data between valid pulses; requester holds req/addr stable until ack.
REQ-016 SHALL, when m_req and s_req are both pending, grant the port not granted last; a single requester is granted every cycle it requests.
REQ-017 SHALL contain a reset sequencer FSM: UNLOADED, LOADING, STRETCH, RUN.
REQ-018 SHALL transition: any state -> LOADING on dl_active rising; LOADING -> STRETCH on dl_active falling (set rom_loaded=1); STRETCH -> RUN when counter reaches 0; RUN -> STRETCH on user_reset.
REQ-019 SHALL load the counter with RST_CYCLES on STRETCH entry and reload it whenever user_reset=1 in STRETCH.
REQ-020 SHALL drive core_reset=1 in every state except RUN; UNLOADED ignores user_reset.
REQ-021 SHALL, on dl_active rising mid-fetch, drop any ungranted request and still deliver the valid pulse for a fetch acked the previous cycle.

Reset
REQ-022 SHALL, on reset_n=0, force FSM=UNLOADED, rom_loaded=0, core_reset=1, acks/valids=0, ram_we=0, x_data=0, last-grant=sound (main wins first tie), counter=0.

Configuration
REQ-023 SHALL, with ROM_ARB_CHECKSUM_EN defined, add port dl_sum out 16: modulo-2^16 sum of dl_data over accepted download writes, cleared on dl_active rising, held afterwards.
REQ-024 SHALL, without ROM_ARB_CHECKSUM_EN, omit dl_sum and its logic entirely.

Structure
REQ-025 SHALL place the sequencer state enum and the grant enum (NONE, DL, MAIN, SND) in package mcr_rom_arb_pkg.
REQ-026 SHALL implement the FSM and counter in sub-module rom_rst_seq; arbitration stays in the top module.

Verification
REQ-027 SHALL cover: reset_n low then high, no download -> core_reset=1, rom_loaded=0 indefinitely; user_reset has no effect.
REQ-028 SHALL cover: download 4 bytes 0x11,0x22,0x33,0x44 to 0x0000-0x0003 -> 4 ram_we pulses; after dl_active falls, rom_loaded=1, core_reset falls exactly RST_CYCLES(set 16) clocks later; with macro, dl_sum=0x00AA.
REQ-029 SHALL cover: m_req and s_req held continuously from reset -> acks alternate M,S,M,S; each x_valid one cycle after its ack with the matching byte.
REQ-030 SHALL cover: fetches pending when dl_active rises -> no further acks until dl_active falls; an ack issued the prior cycle still produces its valid.
REQ-031 SHALL cover: user_reset pulse in RUN -> core_reset=1 for RST_CYCLES; second pulse mid-stretch restarts the count.
